jt12_timer_ctrl: RTL and testbench
==================================

Name: jt12_timer_ctrl

Overview:
CPU-facing register front end for the FM timer pair. It decodes bus writes to registers 0x24–0x27 (part I) and drives the timer block's inputs: value_A, value_B, load_A/B, clr_flag_A/B and enable_irq_A/B. It also composes the status byte from the timer flags and a write-busy counter, and turns timer-A overflow into the CSM key-on pulse for channel 3.

Parameters:
BUSY_CYCLES, 32, number of clk_en ticks the busy bit stays high after a data write (≥1)
BUSY_W, 6, width of the busy counter; must hold BUSY_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
clk_en  in  1  chip cycle enable; same strobe the timer block uses
din  in  8  CPU write data
addr  in  1  0 = address phase, 1 = data phase
a1  in  1  part select; 0 = part I, 1 = part II
cs_n  in  1  chip select, active low
wr_n  in  1  write strobe, active low
flag_A  in  1  timer A flag from timer block
flag_B  in  1  timer B flag from timer block
overflow_A  in  1  timer A overflow from timer block
value_A  out  10  timer A preset NA
value_B  out  8  timer B preset NB
load_A  out  1  timer A run/load level
load_B  out  1  timer B run/load level
enable_irq_A  out  1  IRQ enable for A
enable_irq_B  out  1  IRQ enable for B
clr_flag_A  out  1  one-clk flag-clear pulse for A
clr_flag_B  out  1  one-clk flag-clear pulse for B
ch3_mode  out  2  reg 0x27[7:6]; 00 normal, 01 special, 10/11 CSM
csm_keyon  out  1  CSM key-on for channel 3
dout  out  8  status {busy, 5'b0, flag_B, flag_A}

Behaviour:
- Write detect: wr_act = ~cs_n & ~wr_n, registered every clk. A write is taken on the clk where wr_act is 1 and its registered copy is 0, so each strobe yields exactly one write. clk_en does not qualify bus decode.
- Address phase (addr=0): latch din into sel_addr and a1 into sel_part.
- Data phase (addr=1) when sel_part=0:
  - 0x24: value_A[9:2] <= din.
  - 0x25: value_A[1:0] <= din[1:0].
  - 0x26: value_B <= din.
  - 0x27: ch3_mode <= din[7:6]; enable_irq_B <= din[3]; enable_irq_A <= din[2]; load_B <= din[1]; load_A <= din[0].
  - 0x27 also pulses clr_flag_B = din[5] and clr_flag_A = din[4] high for exactly one clk on the following cycle. Writing 0 to these bits produces no pulse.
  - Any other address is ignored by this block.
- Data phase with sel_part=1: no timer register changes; busy still triggers.
- Register outputs are registered and appear one clk after the write edge.
- Busy: every data-phase write (either part) loads the counter with BUSY_CYCLES. The counter decrements on clk_en while nonzero; busy = (cnt != 0).
  - A write while busy reloads the counter and is still accepted.
  - On the write clk itself the counter loads; the decrement is suppressed that clk.
- dout is combinational from the busy register and the flag inputs.
- CSM: on each clk_en tick, csm_keyon <= ch3_mode[1] & overflow_A. The pulse therefore lasts one clk_en period; without clk_en it holds its value.
- Reset (async, any time, including mid-busy or mid-pulse) clears every output and internal register: value_A=0, value_B=0, load_A/B=0, enable_irq_A/B=0, clr_flag_A/B=0, ch3_mode=0, csm_keyon=0, busy counter=0, sel_addr=0, sel_part=0, edge register=0. dout = {0,5'b0,flag_B,flag_A}.
- A write edge coincident with reset release is not required to register.

Optional Feature:
JT12_TIMER_BUSY_EN:
- Defined: the busy counter is built as described above.
- Undefined: the counter is omitted and dout[7] is constant 0; all other behaviour is unchanged.

Test Plan:
- Write addr 0x24 data 0xAB, then addr 0x25 data 0xFE -> value_A = 10'h2AE one clk after the second write edge; value_B unchanged at 0.
- Write 0x27 = 0x3F -> load_A=load_B=1, enable_irq_A=B=1; clr_flag_A and clr_flag_B each high exactly 1 clk; then write 0x27 = 0x0F -> no clr pulses.
- Write part II (a1=1) addr 0x26 data 0x55 -> value_B stays 0. With JT12_TIMER_BUSY_EN, dout[7]=1 for exactly 32 clk_en ticks (clk_en every 6 clk -> 192 clk).
- Data write at tick 10 of busy, then a second write -> busy extends to 32 ticks from the second write.
- ch3_mode=2'b10, overflow_A held high across one clk_en -> csm_keyon=1 for one clk_en period; with ch3_mode=2'b01 -> csm_keyon stays 0.
- Assert rst mid-busy with loads set -> all outputs 0 immediately; flags injected on flag_A/B appear at dout[1:0] combinationally.

Source files
------------

// File: rtl/jt12_timer_ctrl.sv
// rtl/jt12_timer_ctrl.sv - CPU register front end for the FM timer pair (regs 0x24-0x27, status, CSM key-on)
// Optional feature macro: JT12_TIMER_BUSY_EN builds the write-busy counter behind dout[7].
module jt12_timer_ctrl #(
   parameter int BUSY_CYCLES = 32,
   parameter int BUSY_W      = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic [7:0] din,
   input  logic       addr,
   input  logic       a1,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic       flag_A,
   input  logic       flag_B,
   input  logic       overflow_A,
   output logic [9:0] value_A,
   output logic [7:0] value_B,
   output logic       load_A,
   output logic       load_B,
   output logic       enable_irq_A,
   output logic       enable_irq_B,
   output logic       clr_flag_A,
   output logic       clr_flag_B,
   output logic [1:0] ch3_mode,
   output logic       csm_keyon,
   output logic [7:0] dout
);

   localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(BUSY_CYCLES);

   logic       wr_act;
   logic       wr_q;
   logic       write;
   logic [7:0] sel_addr;
   logic       sel_part;
   logic       busy;

   assign wr_act = ~cs_n & ~wr_n;
   assign write  = wr_act & ~wr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q         <= 1'b0;
         sel_addr     <= 8'd0;
         sel_part     <= 1'b0;
         value_A      <= 10'd0;
         value_B      <= 8'd0;
         load_A       <= 1'b0;
         load_B       <= 1'b0;
         enable_irq_A <= 1'b0;
         enable_irq_B <= 1'b0;
         clr_flag_A   <= 1'b0;
         clr_flag_B   <= 1'b0;
         ch3_mode     <= 2'b00;
         csm_keyon    <= 1'b0;
      end else begin
         wr_q       <= wr_act;
         // flag clears are single-clk strobes; they fall back on any clk without a 0x27 write
         clr_flag_A <= 1'b0;
         clr_flag_B <= 1'b0;
         if (write) begin
            if (!addr) begin
               sel_addr <= din;
               sel_part <= a1;
            end else if (!sel_part) begin
               case (sel_addr)
                  8'h24: value_A[9:2] <= din;
                  8'h25: value_A[1:0] <= din[1:0];
                  8'h26: value_B      <= din;
                  8'h27: begin
                     ch3_mode     <= din[7:6];
                     clr_flag_B   <= din[5];
                     clr_flag_A   <= din[4];
                     enable_irq_B <= din[3];
                     enable_irq_A <= din[2];
                     load_B       <= din[1];
                     load_A       <= din[0];
                  end
                  default: ;
               endcase
            end
         end
         if (clk_en)
            csm_keyon <= ch3_mode[1] & overflow_A;
      end
   end

`ifdef JT12_TIMER_BUSY_EN
   logic [BUSY_W-1:0] busy_cnt;

   // a data write reloads the counter and wins over that clk's decrement
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy_cnt <= '0;
      else if (write && addr)
         busy_cnt <= BUSY_LOAD;
      else if (clk_en && busy_cnt != '0)
         busy_cnt <= busy_cnt - 1'b1;
   end

   assign busy = (busy_cnt != '0);
`else
   logic unused_busy_cfg;

   assign unused_busy_cfg = ^BUSY_LOAD;
   assign busy            = 1'b0;
`endif

   assign dout = {busy, 5'b00000, flag_B, flag_A};

endmodule

// File: tb/tb_jt12_timer_ctrl.sv
// tb/tb_jt12_timer_ctrl.sv - scoreboard bench for jt12_timer_ctrl register decode, busy, CSM and reset
module tb_jt12_timer_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       clk_en = 1'b0;
   logic [7:0] din;
   logic       addr;
   logic       a1;
   logic       cs_n;
   logic       wr_n;
   logic       flag_A;
   logic       flag_B;
   logic       overflow_A;
   logic [9:0] value_A;
   logic [7:0] value_B;
   logic       load_A;
   logic       load_B;
   logic       enable_irq_A;
   logic       enable_irq_B;
   logic       clr_flag_A;
   logic       clr_flag_B;
   logic [1:0] ch3_mode;
   logic       csm_keyon;
   logic [7:0] dout;

   int tests = 0;
   int fails = 0;
   int en_ph = 0;
   int tick_cnt = 0;
   int wtick = 0;

   logic [25:0] exp_q[$];

   logic [7:0] m_sel;
   logic       m_part;
   logic [9:0] m_va;
   logic [7:0] m_vb;
   logic       m_la, m_lb, m_ea, m_eb;
   logic [1:0] m_ch3;

   jt12_timer_ctrl #(.BUSY_CYCLES(32), .BUSY_W(6)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .din(din), .addr(addr), .a1(a1),
      .cs_n(cs_n), .wr_n(wr_n), .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A),
      .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
      .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
      .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B), .ch3_mode(ch3_mode),
      .csm_keyon(csm_keyon), .dout(dout)
   );

   always #5 clk = ~clk;

   // clk_en: one clk in six, changed on the falling edge
   always @(negedge clk) begin
      en_ph  = (en_ph == 5) ? 0 : en_ph + 1;
      clk_en = (en_ph == 0);
   end

   always @(posedge clk) if (clk_en) tick_cnt <= tick_cnt + 1;

   function automatic logic [25:0] snap();
      return {clr_flag_B, clr_flag_A, ch3_mode, enable_irq_B, enable_irq_A, load_B, load_A, value_B, value_A};
   endfunction

   function automatic logic [23:0] mstate();
      return {m_ch3, m_eb, m_ea, m_lb, m_la, m_vb, m_va};
   endfunction

   task automatic model_reset();
      m_sel = 8'd0; m_part = 1'b0; m_va = 10'd0; m_vb = 8'd0;
      m_la = 1'b0; m_lb = 1'b0; m_ea = 1'b0; m_eb = 1'b0; m_ch3 = 2'b00;
   endtask

   task automatic bus_write(input logic ph, input logic part, input logic [7:0] d);
      logic [1:0]  mclr;
      logic [25:0] e;
      logic [25:0] got;
      mclr = 2'b00;
      if (!ph) begin
         m_sel = d; m_part = part;
      end else if (!m_part) begin
         case (m_sel)
            8'h24: m_va[9:2] = d;
            8'h25: m_va[1:0] = d[1:0];
            8'h26: m_vb = d;
            8'h27: begin
               m_ch3 = d[7:6]; m_eb = d[3]; m_ea = d[2]; m_lb = d[1]; m_la = d[0];
               mclr = d[5:4];
            end
            default: ;
         endcase
      end
      exp_q.push_back({mclr, mstate()});
      exp_q.push_back({2'b00, mstate()});
      addr = ph; a1 = part; din = d; cs_n = 1'b0; wr_n = 1'b0;
      @(posedge clk); #1;
      wtick = tick_cnt;
      e = exp_q.pop_front(); got = snap(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL write_edge ph=%0d d=%h: got %h expected %h", ph, d, got, e);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front(); got = snap(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL strobe_hold ph=%0d d=%h: got %h expected %h", ph, d, got, e);
      end
      @(negedge clk);
      cs_n = 1'b1; wr_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_busy_drop(input string name);
      bit dropped;
      dropped = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!dout[7]) begin
            dropped = 1'b1;
            break;
         end
         @(negedge clk);
      end
      tests++;
      if (!dropped) begin
         fails++;
         $display("FAIL %s timeout: busy still %b expected 0", name, dout[7]);
      end else if (tick_cnt - wtick != 32) begin
         fails++;
         $display("FAIL %s ticks: got %0d expected 32", name, tick_cnt - wtick);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; addr = 1'b0; a1 = 1'b0; din = 8'd0;
      flag_A = 1'b0; flag_B = 1'b0; overflow_A = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      tests++;
      if (snap() !== 26'd0 || csm_keyon !== 1'b0 || dout !== 8'h00) begin
         fails++;
         $display("FAIL reset_state: regs %h csm %b dout %h expected 0 0 00", snap(), csm_keyon, dout);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_value_a();
      bus_write(1'b0, 1'b0, 8'h24);
      bus_write(1'b1, 1'b0, 8'hAB);
      bus_write(1'b0, 1'b0, 8'h25);
      bus_write(1'b1, 1'b0, 8'hFE);
      tests++;
      if (value_A !== 10'h2AE || value_B !== 8'h00) begin
         fails++;
         $display("FAIL value_a: got A=%h B=%h expected A=2ae B=00", value_A, value_B);
      end
      bus_write(1'b0, 1'b0, 8'h2A);
      bus_write(1'b1, 1'b0, 8'hFF);
   endtask

   task automatic test_ctrl_reg();
      bus_write(1'b0, 1'b0, 8'h27);
      bus_write(1'b1, 1'b0, 8'h3F);
      tests++;
      if ({load_A, load_B, enable_irq_A, enable_irq_B} !== 4'b1111) begin
         fails++;
         $display("FAIL ctrl_bits: got %b expected 1111", {load_A, load_B, enable_irq_A, enable_irq_B});
      end
      bus_write(1'b1, 1'b0, 8'h0F);
   endtask

   task automatic test_part2_busy();
      bus_write(1'b0, 1'b1, 8'h26);
      bus_write(1'b1, 1'b1, 8'h55);
      tests++;
      if (value_B !== 8'h00) begin
         fails++;
         $display("FAIL part2_value_b: got %h expected 00", value_B);
      end
`ifdef JT12_TIMER_BUSY_EN
      wait_busy_drop("part2_busy");
`else
      tests++;
      if (dout[7] !== 1'b0) begin
         fails++;
         $display("FAIL busy_disabled: got %b expected 0", dout[7]);
      end
`endif
   endtask

   task automatic test_busy_reload();
      bus_write(1'b0, 1'b0, 8'h26);
      bus_write(1'b1, 1'b0, 8'h11);
`ifdef JT12_TIMER_BUSY_EN
      for (int i = 0; i < 200 && (tick_cnt - wtick) < 10; i++) @(negedge clk);
      tests++;
      if (dout[7] !== 1'b1) begin
         fails++;
         $display("FAIL busy_mid: got %b expected 1", dout[7]);
      end
      bus_write(1'b1, 1'b0, 8'h22);
      wait_busy_drop("busy_reload");
`else
      bus_write(1'b1, 1'b0, 8'h22);
`endif
      tests++;
      if (value_B !== 8'h22) begin
         fails++;
         $display("FAIL reload_value_b: got %h expected 22", value_B);
      end
   endtask

   task automatic csm_run(input logic [7:0] mode_byte, input int exp_n, input string name);
      int n;
      bus_write(1'b0, 1'b0, 8'h27);
      bus_write(1'b1, 1'b0, mode_byte);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (clk_en) break;
      end
      overflow_A = 1'b1;
      @(posedge clk); #1;
      overflow_A = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (csm_keyon) n++;
         else if (exp_n != 0 || i >= 12) break;
         @(posedge clk); #1;
      end
      tests++;
      if (n !== exp_n) begin
         fails++;
         $display("FAIL %s: keyon clks got %0d expected %0d", name, n, exp_n);
      end
      @(negedge clk);
   endtask

   task automatic test_csm();
      csm_run(8'h80, 6, "csm_mode10");
      csm_run(8'h40, 0, "csm_mode01");
   endtask

   task automatic test_async_reset();
      bus_write(1'b0, 1'b0, 8'h27);
      bus_write(1'b1, 1'b0, 8'h0F);
      bus_write(1'b0, 1'b0, 8'h26);
      bus_write(1'b1, 1'b0, 8'h77);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      tests++;
      if (snap() !== 26'd0 || csm_keyon !== 1'b0 || dout !== 8'h00) begin
         fails++;
         $display("FAIL async_reset: regs %h csm %b dout %h expected 0 0 00", snap(), csm_keyon, dout);
      end
      flag_A = 1'b1; #1;
      tests++;
      if (dout !== 8'h01) begin
         fails++;
         $display("FAIL flag_a_status: got %h expected 01", dout);
      end
      flag_B = 1'b1; #1;
      tests++;
      if (dout !== 8'h03) begin
         fails++;
         $display("FAIL flag_ab_status: got %h expected 03", dout);
      end
      flag_A = 1'b0; flag_B = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (snap() !== 26'd0 || dout !== 8'h00) begin
         fails++;
         $display("FAIL post_reset: regs %h dout %h expected 0 00", snap(), dout);
      end
   endtask

   initial begin
      test_reset();
      test_value_a();
      test_ctrl_reg();
      test_part2_busy();
      test_busy_reload();
      test_csm();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
